// File: rtl/piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : piso_serializer
// Description : Parallel-in serial-out transmitter with a valid/ready load port,
//               per-word shift direction, stall enable and last-bit marker.
// Revision    : 1.0 - initial release
// ============================================================================
module piso_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] A,
  input  logic         load_valid,
  output logic         load_ready,
  input  logic         RLselect,
  input  logic         enb,
  output logic         sout,
  output logic         sout_valid,
  output logic         last
);

  localparam int            CW      = $clog2(W + 1);
  localparam logic [CW-1:0] c_WORD  = CW'(W);
  localparam logic [CW-1:0] c_ONE   = CW'(1);

  localparam logic [0:0]    c_IDLE  = 1'b0;
  localparam logic [0:0]    c_SHIFT = 1'b1;

  logic [0:0]    r_state;
  logic [0:0]    w_state_nxt;
  logic [W-1:0]  r_sreg;
  logic          r_dir;
  logic [CW-1:0] r_cnt;

  logic          w_in_shift;
  logic          w_final_bit;
  logic          w_final_consume;
  logic          w_load;

  assign w_in_shift      = (r_state == c_SHIFT);
  assign w_final_bit     = w_in_shift & (r_cnt == c_ONE);
  assign w_final_consume = w_final_bit & enb;
  assign w_load          = load_valid & load_ready;

  // The final consumed bit frees the block in the same cycle, so words can abut.
  assign load_ready = (r_state == c_IDLE) | w_final_consume;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_load) begin
      w_state_nxt = c_SHIFT;
    end else if (w_final_consume) begin
      w_state_nxt = c_IDLE;
    end
  end

  // Datapath: shift register, latched direction, remaining-bit counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sreg <= '0;
      r_dir  <= 1'b0;
      r_cnt  <= '0;
    end else if (w_load) begin
      r_sreg <= A;
      r_dir  <= RLselect;
      r_cnt  <= c_WORD;
    end else if (w_in_shift && enb) begin
      if (r_dir) begin
        r_sreg <= {1'b0, r_sreg[W-1:1]};
      end else begin
        r_sreg <= {r_sreg[W-2:0], 1'b0};
      end
      r_cnt <= r_cnt - c_ONE;
    end
  end

  // Output decode, from registers only
  always_comb begin
    sout_valid = 1'b0;
    sout       = 1'b0;
    last       = 1'b0;
    if (w_in_shift) begin
      sout_valid = 1'b1;
      sout       = r_dir ? r_sreg[0] : r_sreg[W-1];
      last       = w_final_bit;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_piso_serializer.sv
`default_nettype none
// ============================================================================
// Module      : tb_piso_serializer
// Description : Directed, table-driven bench for piso_serializer (W = 8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_piso_serializer;

  logic       clk;
  logic       rst;
  logic [7:0] A;
  logic       load_valid;
  logic       load_ready;
  logic       RLselect;
  logic       enb;
  logic       sout;
  logic       sout_valid;
  logic       last;

  int n_cmp;
  int n_err;

  typedef struct {
    logic       lv;
    logic [7:0] a;
    logic       rl;
    logic       en;
    logic       s;
    logic       v;
    logic       l;
    logic       r;
  } vec_t;

  vec_t vecs[$];

  piso_serializer #(.W(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .A          (A),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .RLselect   (RLselect),
    .enb        (enb),
    .sout       (sout),
    .sout_valid (sout_valid),
    .last       (last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int idx, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s [%0d]: got %b expected %b at %0t", name, idx, act, exp, $time);
    end
  endtask

  task automatic add(input logic lv, input logic [7:0] a, input logic rl, input logic en,
                     input logic s, input logic v, input logic l, input logic r);
    vec_t t;
    t.lv = lv; t.a = a; t.rl = rl; t.en = en;
    t.s = s; t.v = v; t.l = l; t.r = r;
    vecs.push_back(t);
  endtask

  // Eight enabled bit-cycles; stream is the expected serial order, leftmost first.
  task automatic add_bits(input logic [7:0] stream, input logic lv, input logic [7:0] a,
                          input logic rl);
    for (int i = 0; i < 8; i++) begin
      add(lv, a, rl, 1'b1, stream[7-i], 1'b1, i == 7, i == 7);
    end
  endtask

  task automatic check_outs(input int idx, input logic s, input logic v, input logic l,
                            input logic r);
    check("sout", idx, sout, s);
    check("sout_valid", idx, sout_valid, v);
    check("last", idx, last, l);
    check("load_ready", idx, load_ready, r);
  endtask

  task automatic drive(input logic lv, input logic [7:0] a, input logic rl, input logic en);
    load_valid = lv;
    A          = a;
    RLselect   = rl;
    enb        = en;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // Idle after reset
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    // LSB-first C4
    add(1'b1, 8'hC4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_bits(8'b00100011, 1'b0, 8'h00, 1'b1);
    // MSB-first C4 (this load row is also the idle check after the first word)
    add(1'b1, 8'hC4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_bits(8'b11000100, 1'b0, 8'h00, 1'b0);
    // LSB-first C4 with a three-cycle stall on bit 2
    add(1'b1, 8'hC4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) add(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    add(1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    // Back-to-back C4 then 3C, next word held on the port the whole time
    add(1'b1, 8'hC4, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    add_bits(8'b00100011, 1'b1, 8'h3C, 1'b1);
    add_bits(8'b00111100, 1'b0, 8'h00, 1'b1);
    // MSB-first C4; load pulse on bit 4 and RLselect toggling must be ignored
    add(1'b1, 8'hC4, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    begin
      logic [7:0] st;
      st = 8'b11000100;
      for (int i = 0; i < 8; i++) begin
        add(i == 3, 8'h00, i[0], 1'b1, st[7-i], 1'b1, i == 7, i == 7);
      end
    end
    add(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);

    // Reset held: outputs quiet
    repeat (2) @(negedge clk);
    #1 check_outs(-1, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    rst = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      @(negedge clk);
      drive(vecs[k].lv, vecs[k].a, vecs[k].rl, vecs[k].en);
      #1 check_outs(k, vecs[k].s, vecs[k].v, vecs[k].l, vecs[k].r);
    end

    // Asynchronous reset mid-word
    @(negedge clk);
    drive(1'b1, 8'hC4, 1'b1, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b1, 1'b1);
    begin
      logic [7:0] st;
      st = 8'b00100011;
      for (int i = 0; i < 3; i++) begin
        #1 check_outs(200 + i, st[7-i], 1'b1, 1'b0, 1'b0);
        @(negedge clk);
      end
    end
    #1 check("rst_pre_valid", 203, sout_valid, 1'b1);
    #1 rst = 1'b0;
    #1 check_outs(204, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1 check_outs(210 + i, 1'b0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
    end
    drive(1'b1, 8'hFF, 1'b0, 1'b1);
    @(negedge clk);
    drive(1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) begin
      #1 check_outs(220 + i, 1'b1, 1'b1, i == 7, i == 7);
      @(negedge clk);
    end
    #1 check_outs(228, 1'b0, 1'b0, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter for the datapath's serial links.
- Accepts a W-bit word through a valid/ready load handshake and shifts it out one bit per enabled cycle, in a direction fixed at load time.
- Marks the final bit of each word.
- Feeds serial inputs of the existing shift-register stages (SIleft/SIright) and off-block serial consumers.

Parameters:
- W, 8, word width in bits (W >= 2).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- A  input  W  parallel word to transmit.
- load_valid  input  1  A holds a word to send.
- load_ready  output  1  block accepts a word this cycle.
- RLselect  input  1  direction, sampled at load: 1 = LSB first, 0 = MSB first.
- enb  input  1  shift enable; 0 stalls transmission.
- sout  output  1  current serial bit.
- sout_valid  output  1  sout carries a valid bit.
- last  output  1  current sout is the final bit of the word.

Behaviour:
- State: FSM {IDLE, SHIFT}, shift register sreg[W-1:0], latched direction dir, bit counter cnt of width $clog2(W+1).
- Reset (rst=0, async):
  - State = IDLE; sreg, dir and cnt = 0.
  - sout = 0, sout_valid = 0, last = 0, load_ready = 1.
  - Effect is immediate, including mid-word: the word in flight is discarded and nothing is resumed.
- Load:
  - A load occurs on a rising edge where load_valid & load_ready.
  - sreg <= A, dir <= RLselect, cnt <= W, state <= SHIFT.
- SHIFT outputs:
  - sout_valid = 1.
  - sout = sreg[0] when dir = 1; sout = sreg[W-1] when dir = 0.
  - last = (cnt == 1).
  - All three are decoded from registers only.
- Consumption:
  - A bit is consumed on each rising edge in SHIFT with enb = 1.
  - dir = 1: sreg <= {1'b0, sreg[W-1:1]}. dir = 0: sreg <= {sreg[W-2:0], 1'b0}.
  - cnt <= cnt - 1.
- Stall: enb = 0 in SHIFT holds sreg, cnt and all outputs unchanged, for any number of cycles.
- End of word: when the last bit is consumed (cnt == 1 & enb), the next state is IDLE, unless a new load occurs in the same cycle.
- load_ready = (state == IDLE) | (state == SHIFT & cnt == 1 & enb).
  - This is combinational from enb.
  - It allows back-to-back words with no gap cycle: the first bit of the next word appears the cycle after the previous last bit.
- Simultaneous last-bit consume and load: the load wins; state stays SHIFT with the new sreg, dir and cnt = W.
- IDLE outputs: sout_valid = 0, last = 0, sout = 0.
- Ignored while busy:
  - load_valid while SHIFT and not on the final consumed bit; A is not sampled.
  - RLselect changes mid-word.
- Latency: load edge to first valid bit is 1 cycle. A word occupies exactly W enabled cycles.
- enb has no effect in IDLE.

Test Plan:
1. Reset, load A=8'hC4, RLselect=1, enb=1 -> sout = 0,0,1,0,0,0,1,1 on 8 consecutive cycles with sout_valid=1; last=1 only on the 8th; IDLE with load_ready=1 on cycle 9.
2. Load A=8'hC4, RLselect=0, enb=1 -> sout = 1,1,0,0,0,1,0,0; last on the 8th bit.
3. A=8'hC4, RLselect=1, enb low for 3 cycles after bit 2 -> sout holds 0 and sout_valid stays 1 during the stall; full sequence as scenario 1, complete in 11 cycles.
4. A=8'hC4 then A=8'h3C held with load_valid=1 (RLselect=1) -> load_ready=1 only during bit 8; sout = 0,0,1,0,0,0,1,1,0,0,1,1,1,1,0,0 with no gap; last on bits 8 and 16.
5. Drop rst to 0 after 3 bits of 8'hC4 -> sout_valid, last and sout go 0 without a clock edge; after release load_ready=1; no further bits; next load of 8'hFF sends eight 1s.
6. During a word, pulse load_valid with A=8'h00 on bit 4 and toggle RLselect -> ignored; original sequence completes unchanged.
